// File: rtl/sparse_encoder_if.sv
// Stream bundle for the sparse encoder: dense vector in, (value, index) beats out.
// master drives vectors and accepts beats; slave is the encoder side.
interface sparse_encoder_if #(
  parameter int DATA_W = 8,
  parameter int N      = 16
);
  logic [N*DATA_W-1:0]  Vector_in;
  logic                 in_valid;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_value;
  logic [$clog2(N)-1:0] out_index;
  logic                 out_last;
  logic                 out_zero;
  logic [$clog2(N):0]   nnz_count;

  modport master (
    output Vector_in, in_valid, out_ready,
    input  in_ready, out_valid, out_value, out_index, out_last, out_zero, nnz_count
  );

  modport slave (
    input  Vector_in, in_valid, out_ready,
    output in_ready, out_valid, out_value, out_index, out_last, out_zero, nnz_count
  );
endinterface

// File: rtl/sparse_encoder.sv
// Compresses one dense vector into a serial stream of nonzero (value, index) beats,
// lowest index first. All outputs are registered; beats follow back-to-back.
//
// state | meaning
// IDLE  | waiting for a vector (in_ready=1 once out of reset)
// EMIT  | presenting the lowest remaining nonzero element
// ZERO  | presenting the single beat of an all-zero vector
module sparse_encoder #(
  parameter int DATA_W = 8,
  parameter int N      = 16
) (
  input  logic           clk,
  input  logic           rst,
  sparse_encoder_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, EMIT, ZERO} state_t;

  state_t              state_q;
  logic [N*DATA_W-1:0] vec_q;
  logic [N-1:0]        mask_q;
  logic [CNT_W-1:0]    nnz_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_value_q;
  logic [IDX_W-1:0]    out_index_q;
  logic                out_last_q;
  logic                out_zero_q;

  logic [N-1:0]        cap_mask;
  logic [CNT_W-1:0]    cap_cnt;
  logic [N-1:0]        nxt_mask;
  logic [N-1:0]        src_mask;
  logic [IDX_W-1:0]    first_idx;
  logic                src_single;
  logic [DATA_W-1:0]   src_value;

  // One encoder serves both the capture cycle (fresh input) and each accepted beat
  // (mask minus the bit just sent), so the next beat is ready without a bubble.
  always_comb begin
    cap_mask  = '0;
    cap_cnt   = '0;
    first_idx = '0;
    for (int i = 0; i < N; i++) begin
      cap_mask[i] = |bus.Vector_in[i*DATA_W +: DATA_W];
      cap_cnt     = cap_cnt + CNT_W'(cap_mask[i]);
    end
    nxt_mask   = mask_q & ~(N'(1) << out_index_q);
    src_mask   = (state_q == IDLE) ? cap_mask : nxt_mask;
    for (int i = N - 1; i >= 0; i--) begin
      if (src_mask[i]) first_idx = IDX_W'(i);
    end
    src_single = ((src_mask & (src_mask - N'(1))) == '0);
    src_value  = (state_q == IDLE) ? bus.Vector_in[int'(first_idx)*DATA_W +: DATA_W]
                                   : vec_q[int'(first_idx)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      mask_q      <= '0;
      nnz_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            vec_q       <= bus.Vector_in;
            mask_q      <= cap_mask;
            nnz_q       <= cap_cnt;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            if (|cap_mask) begin
              state_q     <= EMIT;
              out_value_q <= src_value;
              out_index_q <= first_idx;
              out_last_q  <= src_single;
              out_zero_q  <= 1'b0;
            end else begin
              state_q     <= ZERO;
              out_value_q <= '0;
              out_index_q <= '0;
              out_last_q  <= 1'b1;
              out_zero_q  <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            mask_q <= nxt_mask;
            if (out_last_q) begin
              state_q     <= IDLE;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_value_q <= '0;
              out_index_q <= '0;
              out_last_q  <= 1'b0;
            end else begin
              out_value_q <= src_value;
              out_index_q <= first_idx;
              out_last_q  <= src_single;
            end
          end
        end
        ZERO: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_zero_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign bus.out_index = out_index_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.nnz_count = nnz_q;

endmodule

// File: tb/tb_sparse_encoder.sv
// Directed bench for sparse_encoder: inputs driven and outputs checked on the falling edge.
module tb_sparse_encoder;
  localparam int DATA_W = 8;
  localparam int N      = 16;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  sparse_encoder_if #(.DATA_W(DATA_W), .N(N)) bus ();

  sparse_encoder #(.DATA_W(DATA_W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] val, input logic [3:0] idx,
                          input logic last, input logic zero);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".value"}, 32'(bus.out_value), 32'(val));
    chk({tag, ".index"}, 32'(bus.out_index), 32'(idx));
    chk({tag, ".last"},  32'(bus.out_last),  32'(last));
    chk({tag, ".zero"},  32'(bus.out_zero),  32'(zero));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"},    32'(bus.out_valid), 32'd0);
    chk({tag, ".in_ready"}, 32'(bus.in_ready),  32'd1);
    chk({tag, ".value"},    32'(bus.out_value), 32'd0);
    chk({tag, ".last"},     32'(bus.out_last),  32'd0);
    chk({tag, ".zero"},     32'(bus.out_zero),  32'd0);
  endtask

  // Presents v for one rising edge; returns on the falling edge after capture.
  task automatic send(input logic [N*DATA_W-1:0] v);
    bus.Vector_in = v;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  logic [N*DATA_W-1:0] v;

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b0;
    bus.Vector_in = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.in_ready", 32'(bus.in_ready),  32'd0);
    chk("rst.valid",    32'(bus.out_valid), 32'd0);
    chk("rst.nnz",      32'(bus.nnz_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("rst_rel");

    // three sparse elements, downstream always ready
    v = '0; v[2*8 +: 8] = 8'h05; v[9*8 +: 8] = 8'hFF; v[15*8 +: 8] = 8'h80;
    bus.out_ready = 1'b1;
    send(v);
    chk_beat("t1.b0", 8'h05, 4'd2, 1'b0, 1'b0);
    chk("t1.nnz", 32'(bus.nnz_count), 32'd3);
    chk("t1.in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk_beat("t1.b1", 8'hFF, 4'd9, 1'b0, 1'b0);
    @(negedge clk);
    chk_beat("t1.b2", 8'h80, 4'd15, 1'b1, 1'b0);
    @(negedge clk);
    chk_idle("t1.end");
    chk("t1.nnz_hold", 32'(bus.nnz_count), 32'd3);

    // all-zero vector
    send('0);
    chk_beat("t2.b0", 8'h00, 4'd0, 1'b1, 1'b1);
    chk("t2.nnz", 32'(bus.nnz_count), 32'd0);
    @(negedge clk);
    chk_idle("t2.end");

    // full vector with stalls: element i = i+1
    for (int i = 0; i < N; i++) v[i*8 +: 8] = 8'(i + 1);
    bus.out_ready = 1'b0;
    send(v);
    for (int k = 0; k < N; k++) begin
      chk_beat($sformatf("t3.b%0d", k), 8'(k + 1), 4'(k), (k == N - 1), 1'b0);
      chk("t3.nnz", 32'(bus.nnz_count), 32'd16);
      @(negedge clk);
      chk_beat($sformatf("t3.stall%0d", k), 8'(k + 1), 4'(k), (k == N - 1), 1'b0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    chk_idle("t3.end");
    chk("t3.nnz_hold", 32'(bus.nnz_count), 32'd16);

    // in_valid held high across two vectors
    bus.out_ready = 1'b1;
    v = '0; v[1*8 +: 8] = 8'h11; v[3*8 +: 8] = 8'h33;
    bus.Vector_in = v;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    chk_beat("t4.a0", 8'h11, 4'd1, 1'b0, 1'b0);
    chk("t4.a_nnz", 32'(bus.nnz_count), 32'd2);
    v = '0; v[7*8 +: 8] = 8'h77;
    bus.Vector_in = v;
    @(negedge clk);
    chk_beat("t4.a1", 8'h33, 4'd3, 1'b1, 1'b0);
    chk("t4.a1.in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("t4.gap.valid",    32'(bus.out_valid), 32'd0);
    chk("t4.gap.in_ready", 32'(bus.in_ready),  32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_beat("t4.b0", 8'h77, 4'd7, 1'b1, 1'b0);
    chk("t4.b_nnz", 32'(bus.nnz_count), 32'd1);
    @(negedge clk);
    chk_idle("t4.end");
    @(negedge clk);
    chk("t4.no_dup", 32'(bus.out_valid), 32'd0);

    // reset in mid-stream
    v = '0; v[4*8 +: 8] = 8'h44; v[6*8 +: 8] = 8'h66; v[10*8 +: 8] = 8'hAA;
    send(v);
    chk_beat("t5.b0", 8'h44, 4'd4, 1'b0, 1'b0);
    @(negedge clk);
    chk_beat("t5.b1", 8'h66, 4'd6, 1'b0, 1'b0);
    @(negedge clk);
    chk_beat("t5.b2", 8'hAA, 4'd10, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk("t5.rst.valid",    32'(bus.out_valid), 32'd0);
    chk("t5.rst.in_ready", 32'(bus.in_ready),  32'd0);
    chk("t5.rst.nnz",      32'(bus.nnz_count), 32'd0);
    chk("t5.rst.value",    32'(bus.out_value), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("t5.rel");
    @(negedge clk);
    chk("t5.no_partial", 32'(bus.out_valid), 32'd0);
    v = '0; v[3*8 +: 8] = 8'h30; v[12*8 +: 8] = 8'hC0;
    send(v);
    chk_beat("t5.n0", 8'h30, 4'd3, 1'b0, 1'b0);
    chk("t5.n_nnz", 32'(bus.nnz_count), 32'd2);
    @(negedge clk);
    chk_beat("t5.n1", 8'hC0, 4'd12, 1'b1, 1'b0);
    @(negedge clk);
    chk_idle("t5.end");

    // element 0 only
    v = '0; v[0 +: 8] = 8'h01;
    send(v);
    chk_beat("t6.b0", 8'h01, 4'd0, 1'b1, 1'b0);
    chk("t6.nnz", 32'(bus.nnz_count), 32'd1);
    @(negedge clk);
    chk_idle("t6.end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sparse_encoder.md
SPARSE_ENCODER -- requirements
Module: sparse_encoder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the element width in bits.
REQ-002 The block SHALL have parameter N, default 16, giving the number of elements per vector.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port Vector_in, input, N*DATA_W bits: dense vector; element i occupies bits [i*DATA_W +: DATA_W].
REQ-006 The block SHALL have port in_valid, input, 1 bit: Vector_in is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a vector.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the output beat is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream accepts the beat.
REQ-010 The block SHALL have port out_value, output, DATA_W bits: the nonzero element value.
REQ-011 The block SHALL have port out_index, output, clog2(N) bits (4 at default): the element position.
REQ-012 The block SHALL have port out_last, output, 1 bit: the final beat of the vector.
REQ-013 The block SHALL have port out_zero, output, 1 bit: the vector had no nonzero elements.
REQ-014 The block SHALL have port nnz_count, output, clog2(N)+1 bits (5 at default): the nonzero count of the captured vector.

Function
REQ-015 The block SHALL compress one dense vector into a serial stream of (value, index) beats, covering only nonzero elements, in ascending index order.
REQ-016 The FSM SHALL have states IDLE, EMIT and ZERO.
REQ-017 IDLE: in_ready=1 and out_valid=0.
REQ-018 EMIT and ZERO: in_ready=0.
REQ-019 An input handshake SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-020 On the input handshake, the block SHALL register Vector_in, a per-element nonzero mask and nnz_count.
REQ-021 After the input handshake, the FSM SHALL go to EMIT if the mask is nonzero, else to ZERO.
REQ-022 Latency: out_valid SHALL be 1 on the cycle after the input handshake.
REQ-023 EMIT SHALL present the lowest set mask bit: out_value = that element, out_index = its position.
REQ-024 out_last SHALL be 1 exactly when the presented bit is the only set bit left in the mask.
REQ-025 An output handshake SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-026 On an output handshake, the block SHALL clear the presented mask bit; the next beat follows on the next cycle with no bubble.
REQ-027 On the handshake of the last beat, the FSM SHALL go to IDLE; in_ready SHALL be 1 on the following cycle.
REQ-028 An input handshake SHALL NOT occur in the same cycle as the last output beat.
REQ-029 ZERO SHALL present one beat: out_value=0, out_index=0, out_last=1, out_zero=1.
REQ-030 On the ZERO beat's output handshake, the FSM SHALL go to IDLE.
REQ-031 out_zero SHALL be 0 in EMIT.
REQ-032 While out_valid=1 and out_ready=0, out_value, out_index, out_last, out_zero and nnz_count SHALL hold stable.
REQ-033 out_valid SHALL NOT drop until its beat is accepted.
REQ-034 nnz_count SHALL hold the last captured count until the next input handshake; a full vector gives N (16).
REQ-035 In IDLE, out_value, out_index, out_last and out_zero SHALL be 0.
REQ-036 Changes on in_valid or Vector_in outside IDLE SHALL be ignored.

Reset
REQ-037 When rst=0, the FSM SHALL go to IDLE immediately, without waiting for clk.
REQ-038 When rst=0, the mask, the registered vector, nnz_count and all outputs SHALL clear to 0, except in_ready.
REQ-039 in_ready SHALL be 0 while rst=0 and SHALL be 1 from the first rising edge after rst releases.
REQ-040 A reset in mid-stream SHALL drop the remaining beats; no partial beat SHALL appear after reset releases.

Verification
REQ-041 The bench SHALL cover: elements 2=0x05, 9=0xFF, 15=0x80, others 0, out_ready=1 -> beats (05,2,last0), (FF,9,last0), (80,15,last1) on 3 consecutive cycles starting 1 cycle after capture; nnz_count=3.
REQ-042 The bench SHALL cover: all-zero vector -> one beat (00,0) with out_last=1, out_zero=1, nnz_count=0; then IDLE.
REQ-043 The bench SHALL cover: all 16 elements nonzero, out_ready toggling 1/0 -> 16 beats, index 0..15, outputs stable during stalls, out_last only on index 15, nnz_count=16.
REQ-044 The bench SHALL cover: in_valid held high continuously -> the next vector is captured only on the cycle after the last beat handshake; no vector is lost or duplicated.
REQ-045 The bench SHALL cover: rst=0 after the 2nd beat of a 3-beat vector -> out_valid=0 at once; after release, a new vector streams correctly from its first index.
REQ-046 The bench SHALL cover: element 0 only nonzero (0x01) -> a single beat (01,0) with out_last=1, out_zero=0.
